// File: rtl/turf_udp_out_arb.sv
// Round-robin arbiter sharing the outbound UDP header/payload path
// among the per-port transmit engines (clk156 domain).
module turf_udp_out_arb #(
  parameter int NUM_PORT = 5,
  parameter int PAYLOAD_WIDTH = 64,
  parameter logic [NUM_PORT*16-1:0] PORT =
    {16'd21605, 16'd21601, 16'd21603, 16'd21614, 16'd21618}
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORT*64-1:0]          s_hdr_tdata,
  input  logic [NUM_PORT-1:0]             s_hdr_tvalid,
  output logic [NUM_PORT-1:0]             s_hdr_tready,
  input  logic [NUM_PORT*PAYLOAD_WIDTH-1:0]     s_payload_tdata,
  input  logic [NUM_PORT*PAYLOAD_WIDTH/8-1:0]   s_payload_tkeep,
  input  logic [NUM_PORT-1:0]             s_payload_tlast,
  input  logic [NUM_PORT-1:0]             s_payload_tvalid,
  output logic [NUM_PORT-1:0]             s_payload_tready,
  output logic [63:0]                     m_udphdr_tdata,
  output logic [15:0]                     m_udphdr_tuser,
  output logic                            m_udphdr_tvalid,
  input  logic                            m_udphdr_tready,
  output logic [PAYLOAD_WIDTH-1:0]        m_udpdata_tdata,
  output logic [PAYLOAD_WIDTH/8-1:0]      m_udpdata_tkeep,
  output logic                            m_udpdata_tlast,
  output logic                            m_udpdata_tvalid,
  input  logic                            m_udpdata_tready,
  output logic                            busy,
  output logic [$clog2(NUM_PORT)-1:0]     grant
);

  localparam int GW = $clog2(NUM_PORT);
  localparam int KW = PAYLOAD_WIDTH / 8;
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_PORT - 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  state_t        state;
  logic [GW-1:0] ptr;
  logic [GW-1:0] pick;
  logic          hdr_hs;
  logic          last_hs;

  // First requester at or after ptr, searching upward with wrap.
  function automatic logic [GW-1:0] rr_pick(
    input logic [NUM_PORT-1:0] req,
    input logic [GW-1:0]       p
  );
    logic [GW-1:0] g;
    logic          found;
    int            idx;
    g     = p;
    found = 1'b0;
    for (int i = 0; i < NUM_PORT; i++) begin
      idx = int'(p) + i;
      if (idx >= NUM_PORT) idx = idx - NUM_PORT;
      if (!found && req[idx[GW-1:0]]) begin
        g     = idx[GW-1:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign pick    = rr_pick(s_hdr_tvalid, ptr);
  assign hdr_hs  = m_udphdr_tvalid && m_udphdr_tready;
  assign last_hs = m_udpdata_tvalid && m_udpdata_tready
                   && m_udpdata_tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|s_hdr_tvalid) begin
            grant <= pick;
            busy  <= 1'b1;
            state <= HDR;
          end
        end
        HDR: begin
          if (hdr_hs) state <= DATA;
        end
        DATA: begin
          if (last_hs) begin
            ptr   <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Data lanes follow grant; only valid/ready are gated by state.
  always_comb begin
    m_udphdr_tdata   = s_hdr_tdata[grant*64 +: 64];
    m_udphdr_tuser   = PORT[grant*16 +: 16];
    m_udphdr_tvalid  = 1'b0;
    s_hdr_tready     = '0;
    m_udpdata_tdata  = s_payload_tdata[grant*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    m_udpdata_tkeep  = s_payload_tkeep[grant*KW +: KW];
    m_udpdata_tlast  = s_payload_tlast[grant];
    m_udpdata_tvalid = 1'b0;
    s_payload_tready = '0;
    unique case (state)
      HDR: begin
        m_udphdr_tvalid     = s_hdr_tvalid[grant];
        s_hdr_tready[grant] = m_udphdr_tready;
      end
      DATA: begin
        m_udpdata_tvalid        = s_payload_tvalid[grant];
        s_payload_tready[grant] = m_udpdata_tready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_turf_udp_out_arb.sv
// Scoreboard bench for turf_udp_out_arb: per-port packet sources,
// expected header/beat queues filled as packets are queued.
module tb_turf_udp_out_arb;

  localparam int NP = 5;
  localparam int W  = 64;
  localparam int KW = W / 8;
  localparam logic [15:0] PV [NP] =
    '{16'd21618, 16'd21614, 16'd21603, 16'd21601, 16'd21605};

  logic              clk;
  logic              aresetn;
  logic [NP*64-1:0]  s_hdr_tdata;
  logic [NP-1:0]     s_hdr_tvalid;
  logic [NP-1:0]     s_hdr_tready;
  logic [NP*W-1:0]   s_payload_tdata;
  logic [NP*KW-1:0]  s_payload_tkeep;
  logic [NP-1:0]     s_payload_tlast;
  logic [NP-1:0]     s_payload_tvalid;
  logic [NP-1:0]     s_payload_tready;
  logic [63:0]       m_udphdr_tdata;
  logic [15:0]       m_udphdr_tuser;
  logic              m_udphdr_tvalid;
  logic              m_udphdr_tready;
  logic [W-1:0]      m_udpdata_tdata;
  logic [KW-1:0]     m_udpdata_tkeep;
  logic              m_udpdata_tlast;
  logic              m_udpdata_tvalid;
  logic              m_udpdata_tready;
  logic              busy;
  logic [2:0]        grant;

  turf_udp_out_arb dut (
    .aclk             (clk),
    .aresetn          (aresetn),
    .s_hdr_tdata      (s_hdr_tdata),
    .s_hdr_tvalid     (s_hdr_tvalid),
    .s_hdr_tready     (s_hdr_tready),
    .s_payload_tdata  (s_payload_tdata),
    .s_payload_tkeep  (s_payload_tkeep),
    .s_payload_tlast  (s_payload_tlast),
    .s_payload_tvalid (s_payload_tvalid),
    .s_payload_tready (s_payload_tready),
    .m_udphdr_tdata   (m_udphdr_tdata),
    .m_udphdr_tuser   (m_udphdr_tuser),
    .m_udphdr_tvalid  (m_udphdr_tvalid),
    .m_udphdr_tready  (m_udphdr_tready),
    .m_udpdata_tdata  (m_udpdata_tdata),
    .m_udpdata_tkeep  (m_udpdata_tkeep),
    .m_udpdata_tlast  (m_udpdata_tlast),
    .m_udpdata_tvalid (m_udpdata_tvalid),
    .m_udpdata_tready (m_udpdata_tready),
    .busy             (busy),
    .grant            (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr_of(input int p, input int s);
    return 64'h0123456789ABCDEF + (64'(p) << 40) + (64'(s) << 8);
  endfunction

  function automatic logic [W-1:0] pay_of(input int p, input int s,
                                          input int b);
    return {16'(p), 16'(s), 16'(b), 16'hBEEF};
  endfunction

  function automatic logic [KW-1:0] keep_of(input int b, input int len);
    return (b == len - 1) ? 8'h0F : 8'hFF;
  endfunction

  logic [82:0] hq[$];
  logic [72:0] dq[$];
  int          lq[NP][$];
  int          nseq[NP];
  int          ph[NP];
  int          bt[NP];
  logic [NP-1:0] early;
  logic [NP-1:0] h_hs;
  logic [NP-1:0] d_hs;
  logic        toggle_en;

  int nbeat;
  int hcnt[NP];
  int last_pkt[NP];
  int pkt_no;
  int max_gap;
  logic early_seen;

  task automatic add_pkt(input int p, input int len);
    int s;
    s = nseq[p];
    nseq[p]++;
    lq[p].push_back(s * 256 + len);
    hq.push_back({3'(p), PV[p], hdr_of(p, s)});
    for (int b = 0; b < len; b++)
      dq.push_back({pay_of(p, s, b), keep_of(b, len), b == len - 1});
  endtask

  function automatic bit idle_all();
    bit e;
    e = (hq.size() == 0) && (dq.size() == 0) && !busy;
    for (int p = 0; p < NP; p++)
      if (lq[p].size() != 0) e = 0;
    return e;
  endfunction

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!idle_all()) begin
      if (n >= lim) begin
        chk("wait_done_timeout", 128'(1), 128'(0));
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Packet sources: header first, then payload beats.
  initial begin
    s_hdr_tdata      = '0;
    s_hdr_tvalid     = '0;
    s_payload_tdata  = '0;
    s_payload_tkeep  = '0;
    s_payload_tlast  = '0;
    s_payload_tvalid = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        int e, s, len, b;
        logic hv, pv;
        if (!aresetn) begin
          lq[p].delete();
          ph[p] = 0;
          bt[p] = 0;
        end else if (ph[p] == 0) begin
          if (h_hs[p]) begin
            ph[p] = 1;
            bt[p] = 0;
          end
        end else if (d_hs[p]) begin
          bt[p]++;
          if (bt[p] == lq[p][0] % 256) begin
            void'(lq[p].pop_front());
            ph[p] = 0;
          end
        end
        e   = (lq[p].size() > 0) ? lq[p][0] : 0;
        s   = e / 256;
        len = e % 256;
        hv  = (lq[p].size() > 0) && (ph[p] == 0);
        pv  = (ph[p] == 1) || (hv && early[p]);
        b   = (ph[p] == 1) ? bt[p] : 0;
        s_hdr_tvalid[p]             = hv;
        s_hdr_tdata[p*64 +: 64]     = hv ? hdr_of(p, s) : 64'h0;
        s_payload_tvalid[p]         = pv;
        s_payload_tdata[p*W +: W]   = pay_of(p, s, b);
        s_payload_tkeep[p*KW +: KW] = keep_of(b, len);
        s_payload_tlast[p]          = pv && (b == len - 1);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) m_udpdata_tready = ~m_udpdata_tready;
    end
  end

  // Output monitor and scoreboard compare.
  initial begin
    logic [82:0] he;
    logic [72:0] de;
    logic        tl_prev;
    logic [NP-1:0] phm, pend;
    int          gp;
    tl_prev = 1'b0;
    forever begin
      @(negedge clk);
      h_hs = s_hdr_tvalid & s_hdr_tready;
      d_hs = s_payload_tvalid & s_payload_tready;
      if (!aresetn) begin
        tl_prev = 1'b0;
        h_hs    = '0;
        d_hs    = '0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          phm[p]  = (ph[p] == 1);
          pend[p] = (ph[p] == 0) && (lq[p].size() > 0);
        end
        chk("pay_rdy_before_hdr", 128'(s_payload_tready & ~phm), 128'(0));
        chk("hdr_rdy_stray", 128'(s_hdr_tready & ~pend), 128'(0));
        chk("hdr_pay_same_cycle",
            128'(m_udphdr_tvalid && m_udphdr_tready &&
                 m_udpdata_tvalid && m_udpdata_tready), 128'(0));
        if (s_payload_tvalid[3] && !s_payload_tready[3] && ph[3] == 0)
          early_seen = 1'b1;
        if (tl_prev) begin
          chk("busy_after_last", 128'(busy), 128'(0));
          chk("turnaround_hdr_valid", 128'(m_udphdr_tvalid), 128'(0));
        end
        if (m_udphdr_tvalid && m_udphdr_tready) begin
          if (hq.size() == 0) begin
            chk("hdr_unexpected", 128'(1), 128'(0));
          end else begin
            he = hq.pop_front();
            chk("hdr_tdata", 128'(m_udphdr_tdata), 128'(he[63:0]));
            chk("hdr_tuser", 128'(m_udphdr_tuser), 128'(he[79:64]));
            chk("hdr_grant", 128'(grant), 128'(he[82:80]));
            gp = int'(he[82:80]);
            hcnt[gp]++;
            if (last_pkt[gp] >= 0 && pkt_no - last_pkt[gp] - 1 > max_gap)
              max_gap = pkt_no - last_pkt[gp] - 1;
            last_pkt[gp] = pkt_no;
            pkt_no++;
          end
        end
        if (m_udpdata_tvalid && m_udpdata_tready) begin
          nbeat++;
          if (dq.size() == 0) begin
            chk("beat_unexpected", 128'(1), 128'(0));
          end else begin
            de = dq.pop_front();
            chk("beat", 128'({m_udpdata_tdata, m_udpdata_tkeep,
                              m_udpdata_tlast}), 128'(de));
          end
        end
        tl_prev = m_udpdata_tvalid && m_udpdata_tready && m_udpdata_tlast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    hq.delete();
    dq.delete();
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic clr_stats();
    nbeat   = 0;
    pkt_no  = 0;
    max_gap = 0;
    for (int p = 0; p < NP; p++) begin
      hcnt[p]     = 0;
      last_pkt[p] = -1;
    end
  endtask

  initial begin
    int n;
    aresetn          = 1'b0;
    m_udphdr_tready  = 1'b0;
    m_udpdata_tready = 1'b0;
    toggle_en        = 1'b0;
    early            = '0;
    early_seen       = 1'b0;
    h_hs             = '0;
    d_hs             = '0;
    for (int p = 0; p < NP; p++) begin
      nseq[p] = 0;
      ph[p]   = 0;
      bt[p]   = 0;
    end
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_hdr_valid", 128'(m_udphdr_tvalid), 128'(0));
    chk("rst_data_valid", 128'(m_udpdata_tvalid), 128'(0));
    chk("rst_readies", 128'({s_hdr_tready, s_payload_tready}), 128'(0));
    aresetn = 1'b1;

    // Single request, header latency and tuser.
    @(posedge clk);
    #1;
    m_udpdata_tready = 1'b1;
    add_pkt(0, 3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_hdr_tvalid[0] && n < 20);
    chk("t1_src_valid", 128'(s_hdr_tvalid[0]), 128'(1));
    chk("t1_lat_t0", 128'(m_udphdr_tvalid), 128'(0));
    @(negedge clk);
    chk("t1_lat_t1", 128'(m_udphdr_tvalid), 128'(1));
    chk("t1_tuser", 128'(m_udphdr_tuser), 128'(21618));
    chk("t1_busy", 128'(busy), 128'(1));
    @(posedge clk);
    #1;
    m_udphdr_tready = 1'b1;
    wait_done(100);
    chk("t1_beats", 128'(nbeat), 128'(3));

    // Round robin among 0, 2, 4 with 0 re-requesting.
    do_reset();
    @(posedge clk);
    #1;
    add_pkt(0, 1);
    add_pkt(2, 1);
    add_pkt(4, 1);
    add_pkt(0, 1);
    wait_done(200);

    // Header then payload backpressure on an 8-beat packet.
    @(posedge clk);
    #1;
    clr_stats();
    m_udphdr_tready = 1'b0;
    add_pkt(1, 8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_udphdr_tvalid && n < 20);
    repeat (4) @(negedge clk);
    chk("bp_hdr_held", 128'(m_udphdr_tvalid), 128'(1));
    chk("bp_hdr_pending", 128'(hq.size()), 128'(1));
    chk("bp_src_rdy", 128'(s_hdr_tready), 128'(0));
    @(posedge clk);
    #1;
    m_udphdr_tready = 1'b1;
    toggle_en       = 1'b1;
    wait_done(200);
    @(posedge clk);
    #1;
    toggle_en        = 1'b0;
    m_udpdata_tready = 1'b1;
    chk("bp_beats", 128'(nbeat), 128'(8));

    // Payload offered before its header.
    clr_stats();
    early[3] = 1'b1;
    add_pkt(3, 1);
    wait_done(100);
    early[3] = 1'b0;
    chk("early_stall_seen", 128'(early_seen), 128'(1));
    chk("early_beats", 128'(nbeat), 128'(1));

    // Reset during beat 2 of a 4-beat packet.
    @(posedge clk);
    #1;
    clr_stats();
    add_pkt(1, 4);
    n = 0;
    while (nbeat < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_beat1", 128'(nbeat), 128'(1));
    @(posedge clk);
    #3;
    chk("rst_mid_pre_grant", 128'(grant), 128'(1));
    aresetn = 1'b0;
    #1;
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_grant", 128'(grant), 128'(0));
    chk("rst_mid_valids",
        128'({m_udphdr_tvalid, m_udpdata_tvalid}), 128'(0));
    chk("rst_mid_readies",
        128'({s_hdr_tready, s_payload_tready}), 128'(0));
    hq.delete();
    dq.delete();
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    add_pkt(4, 1);
    wait_done(100);
    chk("rst_port4_served", 128'(hcnt[4]), 128'(1));

    // Saturation: rotation from ptr 0, 50 packets.
    @(posedge clk);
    #1;
    clr_stats();
    for (int k = 0; k < 10; k++)
      for (int p = 0; p < NP; p++)
        add_pkt(p, 1 + (k + p) % 3);
    wait_done(2000);
    for (int p = 0; p < NP; p++)
      chk($sformatf("sat_grants_%0d", p), 128'(hcnt[p]), 128'(10));
    chk("sat_max_gap", 128'(max_gap), 128'(4));
    chk("end_hq_empty", 128'(hq.size()), 128'(0));
    chk("end_dq_empty", 128'(dq.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
